price_level_config_writer: RTL

- Generates the config-write side of the price/volume lookup. It accepts incremental per-symbol level updates (set or delete at a price) and keeps a shadow copy of all NUMBER_OF_LEVELS price/volume pairs per symbol.
- Each update runs as a read-modify-write on the shadow copy. The block then emits one full-width config write (symbol index, packed prices, packed volumes) to the lookup's config bus.
- It sits between the book-update source and the lookup's in_config_* inputs.

---
 rtl/price_level_config_writer_if.sv | 55 +++++
 rtl/price_level_config_writer.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/price_level_config_writer_if.sv
// Update request channel and lookup config-write channel of the price level config writer.
// The block side uses the slave modport; the update source / lookup side uses master.
interface price_level_config_writer_if #(
  parameter int unsigned NUMBER_OF_LEVELS = 3,
  parameter int unsigned DROP_CNT_W       = 16
);

  logic                           upd_valid;
  logic                           upd_ready;
  logic                           upd_op;
  logic [7:0]                     upd_symbol_index;
  logic [31:0]                    upd_price;
  logic [31:0]                    upd_volume;

  logic                           out_config_valid;
  logic [7:0]                     out_config_symbol_index;
  logic [NUMBER_OF_LEVELS*32-1:0] out_config_price;
  logic [NUMBER_OF_LEVELS*32-1:0] out_config_volume;
  logic                           out_drop;
  logic [DROP_CNT_W-1:0]          out_drop_count;
  logic                           out_init_done;

  modport master (
    output upd_valid,
    output upd_op,
    output upd_symbol_index,
    output upd_price,
    output upd_volume,
    input  upd_ready,
    input  out_config_valid,
    input  out_config_symbol_index,
    input  out_config_price,
    input  out_config_volume,
    input  out_drop,
    input  out_drop_count,
    input  out_init_done
  );

  modport slave (
    input  upd_valid,
    input  upd_op,
    input  upd_symbol_index,
    input  upd_price,
    input  upd_volume,
    output upd_ready,
    output out_config_valid,
    output out_config_symbol_index,
    output out_config_price,
    output out_config_volume,
    output out_drop,
    output out_drop_count,
    output out_init_done
  );

endinterface

// File: rtl/price_level_config_writer.sv
// Keeps a shadow copy of every symbol's price/volume levels, applies set/delete updates as a
// read-modify-write and emits one full-width config write per changed symbol.
module price_level_config_writer #(
  parameter int unsigned NUMBER_OF_LEVELS = 3,
  parameter int unsigned DROP_CNT_W       = 16
) (
  input logic                      clk,
  input logic                      reset_n,
  price_level_config_writer_if.slave bus
);

  localparam int unsigned BusW   = NUMBER_OF_LEVELS * 32;
  localparam int unsigned EntryW = 2 * BusW;

  typedef enum logic [2:0] {
    StInit,
    StIdle,
    StRead,
    StModify,
    StEmit
  } state_e;

  state_e state_q, state_d;
  logic [7:0] sweep_q, sweep_d;

  // Captured update
  logic        op_q;
  logic [7:0]  idx_q;
  logic [31:0] price_q;
  logic [31:0] vol_q;
  logic        capture;

  // Shadow RAM: volumes in the upper half, prices in the lower half of each entry
  logic [EntryW-1:0] mem_q [256];
  logic [EntryW-1:0] entry_q;
  logic              mem_we;
  logic [7:0]        mem_waddr;
  logic [EntryW-1:0] mem_wdata;

  // Output registers
  logic                  cfg_valid_q, cfg_valid_d;
  logic [7:0]            cfg_idx_q, cfg_idx_d;
  logic [BusW-1:0]       cfg_price_q, cfg_price_d;
  logic [BusW-1:0]       cfg_vol_q, cfg_vol_d;
  logic                  drop_q, drop_d;
  logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic                  init_done_q, init_done_d;

  // Modify-stage results
  logic [BusW-1:0] cur_price, cur_vol;
  logic [BusW-1:0] new_price, new_vol;
  logic            is_delete;
  logic            match_found, free_found;
  int unsigned     match_lvl, free_lvl;
  logic            mod_write, mod_drop;

  always_comb begin
    cur_price   = entry_q[BusW-1:0];
    cur_vol     = entry_q[EntryW-1:BusW];
    new_price   = cur_price;
    new_vol     = cur_vol;
    is_delete   = op_q || (vol_q == '0);
    match_found = 1'b0;
    free_found  = 1'b0;
    match_lvl   = 0;
    free_lvl    = 0;
    mod_write   = 1'b0;
    mod_drop    = 1'b0;

    // Lowest matching level and lowest empty level
    for (int i = 0; i < NUMBER_OF_LEVELS; i++) begin
      if (!match_found && (cur_price[32*i +: 32] == price_q)) begin
        match_found = 1'b1;
        match_lvl   = i;
      end
      if (!free_found && (cur_price[32*i +: 32] == '0)) begin
        free_found = 1'b1;
        free_lvl   = i;
      end
    end

    if (price_q == '0) begin
      mod_drop = 1'b1;
    end else if (is_delete) begin
      mod_write = match_found;
    end else if (match_found || free_found) begin
      mod_write = 1'b1;
    end else begin
      mod_drop = 1'b1;
    end

    for (int i = 0; i < NUMBER_OF_LEVELS; i++) begin
      if (price_q != '0) begin
        if (is_delete) begin
          if (match_found && (match_lvl == i)) begin
            new_price[32*i +: 32] = '0;
            new_vol[32*i +: 32]   = '0;
          end
        end else if (match_found) begin
          if (match_lvl == i) begin
            new_vol[32*i +: 32] = vol_q;
          end
        end else if (free_found && (free_lvl == i)) begin
          new_price[32*i +: 32] = price_q;
          new_vol[32*i +: 32]   = vol_q;
        end
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    sweep_d     = sweep_q;
    capture     = 1'b0;
    mem_we      = 1'b0;
    mem_waddr   = idx_q;
    mem_wdata   = {new_vol, new_price};
    cfg_valid_d = 1'b0;
    cfg_idx_d   = cfg_idx_q;
    cfg_price_d = cfg_price_q;
    cfg_vol_d   = cfg_vol_q;
    drop_d      = 1'b0;
    drop_cnt_d  = drop_cnt_q;
    init_done_d = init_done_q;

    unique case (state_q)
      StInit: begin
        // Clear shadow and downstream lookup one index per cycle
        mem_we      = 1'b1;
        mem_waddr   = sweep_q;
        mem_wdata   = '0;
        cfg_valid_d = 1'b1;
        cfg_idx_d   = sweep_q;
        cfg_price_d = '0;
        cfg_vol_d   = '0;
        sweep_d     = sweep_q + 8'd1;
        if (sweep_q == 8'hff) begin
          state_d     = StIdle;
          init_done_d = 1'b1;
        end
      end
      StIdle: begin
        if (bus.upd_valid) begin
          capture = 1'b1;
          state_d = StRead;
        end
      end
      StRead: begin
        state_d = StModify;
      end
      StModify: begin
        if (mod_write) begin
          mem_we      = 1'b1;
          cfg_valid_d = 1'b1;
          cfg_idx_d   = idx_q;
          cfg_price_d = new_price;
          cfg_vol_d   = new_vol;
        end
        if (mod_drop) begin
          drop_d = 1'b1;
          if (drop_cnt_q != '1) begin
            drop_cnt_d = drop_cnt_q + DROP_CNT_W'(1);
          end
        end
        state_d = StEmit;
      end
      StEmit: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StInit;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= StInit;
      sweep_q     <= '0;
      op_q        <= 1'b0;
      idx_q       <= '0;
      price_q     <= '0;
      vol_q       <= '0;
      cfg_valid_q <= 1'b0;
      cfg_idx_q   <= '0;
      cfg_price_q <= '0;
      cfg_vol_q   <= '0;
      drop_q      <= 1'b0;
      drop_cnt_q  <= '0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sweep_q     <= sweep_d;
      cfg_valid_q <= cfg_valid_d;
      cfg_idx_q   <= cfg_idx_d;
      cfg_price_q <= cfg_price_d;
      cfg_vol_q   <= cfg_vol_d;
      drop_q      <= drop_d;
      drop_cnt_q  <= drop_cnt_d;
      init_done_q <= init_done_d;
      if (capture) begin
        op_q    <= bus.upd_op;
        idx_q   <= bus.upd_symbol_index;
        price_q <= bus.upd_price;
        vol_q   <= bus.upd_volume;
      end
    end
  end

  // Single-port shadow: written in INIT/MODIFY, read only in READ
  always_ff @(posedge clk) begin
    if (reset_n && mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
    if (state_q == StRead) begin
      entry_q <= mem_q[idx_q];
    end
  end

  assign bus.upd_ready               = (state_q == StIdle);
  assign bus.out_config_valid        = cfg_valid_q;
  assign bus.out_config_symbol_index = cfg_idx_q;
  assign bus.out_config_price        = cfg_price_q;
  assign bus.out_config_volume       = cfg_vol_q;
  assign bus.out_drop                = drop_q;
  assign bus.out_drop_count          = drop_cnt_q;
  assign bus.out_init_done           = init_done_q;

endmodule
